desired_drive: RTL and testbench

Combinational-math, pipelined assist-current calculator for the e-bike motor controller. It takes the rider's averaged pedal torque, the cadence measure, the road incline and the assist-level setting. It produces a 12-bit unsigned target motor current for the downstream current/PID loop. It sits between the sensor-conditioning blocks (torque averaging, cadence measurement, inertial incline) and the brushless drive controller.

---
 rtl/desired_drive_if.sv | 24 ++
 rtl/desired_drive.sv | 133 +++++++++++++
 tb/tb_desired_drive.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/desired_drive_if.sv
// Sensor-to-drive bus for desired_drive: conditioned rider inputs in, target current out.
interface desired_drive_if;
  localparam int unsigned TORQUE_W  = 12;
  localparam int unsigned CADENCE_W = 5;
  localparam int unsigned INCLINE_W = 13;
  localparam int unsigned SETTING_W = 2;
  localparam int unsigned CURR_W    = 12;

  logic [TORQUE_W-1:0]  avg_torque;
  logic [CADENCE_W-1:0] cadence_vec;
  logic [INCLINE_W-1:0] incline;
  logic [SETTING_W-1:0] setting;
  logic [CURR_W-1:0]    target_curr;

  modport master (
    output avg_torque, cadence_vec, incline, setting,
    input  target_curr
  );

  modport slave (
    input  avg_torque, cadence_vec, incline, setting,
    output target_curr
  );
endinterface

// File: rtl/desired_drive.sv
// Assist-current calculator: torque x incline x cadence x setting, saturated to 12 bits.
// Define DESIRED_DRIVE_PIPE_EN for the 3-stage pipelined build (latency 3); default is latency 1.
module desired_drive (
  input  logic            clk,
  input  logic            rst_n,
  desired_drive_if.slave  dd
);

  localparam int unsigned TORQUE_W  = 12;
  localparam int unsigned CADENCE_W = 5;
  localparam int unsigned INCLINE_W = 13;
  localparam int unsigned SETTING_W = 2;
  localparam int unsigned CURR_W    = 12;
  localparam int unsigned LIM_W     = 9;
  localparam int unsigned CADF_W    = 6;
  localparam int unsigned TL_W      = TORQUE_W + LIM_W;   // 21
  localparam int unsigned CS_W      = CADF_W + SETTING_W; // 8
  localparam int unsigned PROD_W    = TL_W + CS_W;        // 29
  localparam logic [TORQUE_W-1:0] TORQUE_MIN = 12'h380;

  // Clamp incline, bias by +256, then limit the factor to 0..511.
  function automatic logic [LIM_W-1:0] incline_limit(input logic [INCLINE_W-1:0] inc_u);
    logic signed [INCLINE_W-1:0] inc;
    logic signed [9:0]           sat;
    logic signed [10:0]          fac;
    inc = $signed(inc_u);
    if (inc > 13'sd511)
      sat = 10'sd511;
    else if (inc < -13'sd512)
      sat = -10'sd512;
    else
      sat = $signed(inc_u[9:0]);
    fac = $signed({sat[9], sat}) + 11'sd256;
    if (fac[10])
      incline_limit = '0;
    else if (fac > 11'sd511)
      incline_limit = 9'd511;
    else
      incline_limit = fac[8:0];
  endfunction

  function automatic logic [CADF_W-1:0] cadence_factor(input logic [CADENCE_W-1:0] cad);
    if (cad > 5'd1)
      cadence_factor = {1'b0, cad} + 6'd32;
    else
      cadence_factor = '0;
  endfunction

  // Remove the pedal deadband; anything at or below TORQUE_MIN yields zero.
  function automatic logic [TORQUE_W-1:0] torque_positive(input logic [TORQUE_W-1:0] t);
    logic [TORQUE_W:0] off;
    off = {1'b0, t} - {1'b0, TORQUE_MIN};
    if (off[TORQUE_W])
      torque_positive = '0;
    else
      torque_positive = off[TORQUE_W-1:0];
  endfunction

  function automatic logic [CURR_W-1:0] saturate(input logic [PROD_W-1:0] p);
    if (|p[28:26])
      saturate = 12'hFFF;
    else
      saturate = p[25:14];
  endfunction

  logic [LIM_W-1:0]    lim_c;
  logic [CADF_W-1:0]   cadf_c;
  logic [TORQUE_W-1:0] torque_c;

  always_comb begin
    lim_c    = incline_limit(dd.incline);
    cadf_c   = cadence_factor(dd.cadence_vec);
    torque_c = torque_positive(dd.avg_torque);
  end

  logic [CURR_W-1:0] target_d, target_q;

`ifdef DESIRED_DRIVE_PIPE_EN
  logic [LIM_W-1:0]     lim_d,    lim_q;
  logic [CADF_W-1:0]    cadf_d,   cadf_q;
  logic [TORQUE_W-1:0]  torque_d, torque_q;
  logic [SETTING_W-1:0] set_d,    set_q;
  logic [TL_W-1:0]      tl_d,     tl_q;
  logic [CS_W-1:0]      cs_d,     cs_q;

  // Stage 1 factors, stage 2 partial products, stage 3 saturated result.
  always_comb begin
    lim_d    = lim_c;
    cadf_d   = cadf_c;
    torque_d = torque_c;
    set_d    = dd.setting;
    tl_d     = TL_W'(torque_q) * TL_W'(lim_q);
    cs_d     = CS_W'(cadf_q) * CS_W'(set_q);
    target_d = saturate(PROD_W'(tl_q) * PROD_W'(cs_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lim_q    <= '0;
      cadf_q   <= '0;
      torque_q <= '0;
      set_q    <= '0;
      tl_q     <= '0;
      cs_q     <= '0;
      target_q <= '0;
    end else begin
      lim_q    <= lim_d;
      cadf_q   <= cadf_d;
      torque_q <= torque_d;
      set_q    <= set_d;
      tl_q     <= tl_d;
      cs_q     <= cs_d;
      target_q <= target_d;
    end
  end
`else
  // Full-width product computed in one cycle into the output register.
  always_comb begin
    target_d = saturate(PROD_W'(torque_c) * PROD_W'(lim_c) *
                        PROD_W'(cadf_c) * PROD_W'(dd.setting));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      target_q <= '0;
    else
      target_q <= target_d;
  end
`endif

  assign dd.target_curr = target_q;

endmodule

// File: tb/tb_desired_drive.sv
// Scoreboard bench for desired_drive: expected currents queued on drive, popped after the build latency.
module tb_desired_drive;

`ifdef DESIRED_DRIVE_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  desired_drive_if dd_if ();

  desired_drive u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dd    (dd_if)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: target_curr=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Straight integer reference of the assist formula.
  function automatic logic [11:0] model(input logic [11:0] t, input logic [4:0] c,
                                        input logic [12:0] inc, input logic [1:0] s);
    int iv, lim, cf, tp;
    longint p;
    iv = $signed(inc);
    if (iv > 511) iv = 511;
    if (iv < -512) iv = -512;
    iv = iv + 256;
    lim = (iv < 0) ? 0 : ((iv > 511) ? 511 : iv);
    cf = (c > 1) ? int'(c) + 32 : 0;
    tp = (int'(t) > 896) ? int'(t) - 896 : 0;
    p = longint'(tp) * lim * cf * int'(s);
    if (p >= (longint'(1) << 26)) return 12'hFFF;
    return 12'(p >> 14);
  endfunction

  task automatic apply(input logic [11:0] t, input logic [4:0] c,
                       input logic [12:0] inc, input logic [1:0] s);
    logic [11:0] e;
    @(negedge clk);
    if (exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      check("sb", dd_if.target_curr, e);
    end
    dd_if.avg_torque  = t;
    dd_if.cadence_vec = c;
    dd_if.incline     = inc;
    dd_if.setting     = s;
    exp_q.push_back(model(t, c, inc, s));
  endtask

  // Asynchronous assert mid-cycle, hold with random inputs, release on a negedge.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async", dd_if.target_curr, 12'h000);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("rst_hold", dd_if.target_curr, 12'h000);
      dd_if.avg_torque  = 12'($urandom);
      dd_if.cadence_vec = 5'($urandom);
      dd_if.incline     = 13'($urandom);
      dd_if.setting     = 2'($urandom);
    end
    @(negedge clk);
    check("rst_hold", dd_if.target_curr, 12'h000);
    rst_n = 1'b1;
    repeat (LAT - 1) exp_q.push_back(12'h000);
    exp_q.push_back(model(dd_if.avg_torque, dd_if.cadence_vec, dd_if.incline, dd_if.setting));
  endtask

  typedef struct {
    string       tag;
    logic [11:0] t;
    logic [4:0]  c;
    logic [12:0] inc;
    logic [1:0]  s;
    logic [11:0] exp;
  } scn_t;

  scn_t scn[$];

  initial begin
    rst_n             = 1'b0;
    dd_if.avg_torque  = 12'h800;
    dd_if.cadence_vec = 5'h10;
    dd_if.incline     = 13'h0150;
    dd_if.setting     = 2'd2;

    scn.push_back('{"nominal",    12'h800, 5'h10, 13'h0150, 2'd2, 12'hD79});
    scn.push_back('{"downhill",   12'h800, 5'h10, 13'h1F22, 2'd3, 12'h158});
    scn.push_back('{"deadband",   12'h360, 5'h10, 13'h00C0, 2'd3, 12'h000});
    scn.push_back('{"steep_down", 12'h800, 5'h18, 13'h1EF0, 2'd3, 12'h000});
    scn.push_back('{"flat",       12'h7E0, 5'h18, 13'h0000, 2'd3, 12'hB7C});
    scn.push_back('{"sat_onset",  12'h7E0, 5'h18, 13'h0080, 2'd3, 12'hFFF});
    scn.push_back('{"cadence_1",  12'h800, 5'h01, 13'h0150, 2'd2, 12'h000});
    scn.push_back('{"setting_0",  12'h800, 5'h10, 13'h0150, 2'd0, 12'h000});
    scn.push_back('{"inc_511",    12'h400, 5'h18, 13'h01FF, 2'd1, 12'h0DF});
    scn.push_back('{"inc_clamp",  12'h400, 5'h18, 13'h0FFF, 2'd1, 12'h0DF});
    scn.push_back('{"inc_negmax", 12'hFFF, 5'h1F, 13'h1000, 2'd3, 12'h000});

    do_reset();

    foreach (scn[i]) begin
      repeat (20) apply(scn[i].t, scn[i].c, scn[i].inc, scn[i].s);
      check(scn[i].tag, dd_if.target_curr, scn[i].exp);
    end

    // Back-to-back random vectors exercise throughput and exact latency.
    repeat (200)
      apply(12'($urandom), 5'($urandom), 13'($urandom), 2'($urandom));

    // Reset in the middle of a busy stream, then recover.
    do_reset();
    repeat (20) apply(12'h800, 5'h10, 13'h0150, 2'd2);
    check("post_reset", dd_if.target_curr, 12'hD79);

    repeat (100)
      apply(12'($urandom_range(12'h300, 12'hFFF)), 5'($urandom), 13'($urandom_range(0, 1023) - 512), 2'($urandom));
    repeat (LAT) apply(12'h7E0, 5'h18, 13'h0000, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
